// File: rtl/hazard_unit.sv
// hazard_unit: stall, flush and forwarding control for the five-stage core, with a shadow M/W copy.
// Define HAZARD_DMEM_TIMEOUT_EN to bound data-memory waits to TIMEOUT cycles and raise mem_err.
module hazard_unit #(
   parameter int TIMEOUT = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [4:0] rsD,
   input  logic [4:0] rtD,
   input  logic       branchD,
   input  logic       pcsrcD,
   input  logic [4:0] rsE,
   input  logic [4:0] rtE,
   input  logic [4:0] writeregE,
   input  logic       RegWriteE,
   input  logic       MemtoRegE,
   input  logic       MemWriteE,
   input  logic       mem_ready,
   output logic       stallF,
   output logic       stallD,
   output logic       flushD,
   output logic       flushE,
   output logic       stallB,
   output logic [1:0] forwardAE,
   output logic [1:0] forwardBE,
   output logic       forwardAD,
   output logic       forwardBD,
   output logic       mem_err
);
   logic [4:0] writeregM_q, writeregW_q;
   logic       RegWriteM_q, RegWriteW_q, MemtoRegM_q, memaccM_q;
   logic       lwstall, brstall, memstall, tmo;

   if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
      $error("hazard_unit: TIMEOUT must be in 2..255");
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         writeregM_q <= 5'd0;
         writeregW_q <= 5'd0;
         RegWriteM_q <= 1'b0;
         RegWriteW_q <= 1'b0;
         MemtoRegM_q <= 1'b0;
         memaccM_q   <= 1'b0;
      end else if (!stallB) begin
         writeregM_q <= writeregE;
         writeregW_q <= writeregM_q;
         RegWriteM_q <= RegWriteE;
         RegWriteW_q <= RegWriteM_q;
         MemtoRegM_q <= MemtoRegE;
         memaccM_q   <= MemtoRegE | MemWriteE;
      end

   // M has priority over W; register 0 is never forwarded
   assign forwardAE = (rsE != 5'd0 && rsE == writeregM_q && RegWriteM_q) ? 2'b10 :
                      (rsE != 5'd0 && rsE == writeregW_q && RegWriteW_q) ? 2'b01 : 2'b00;
   assign forwardBE = (rtE != 5'd0 && rtE == writeregM_q && RegWriteM_q) ? 2'b10 :
                      (rtE != 5'd0 && rtE == writeregW_q && RegWriteW_q) ? 2'b01 : 2'b00;
   assign forwardAD = rsD != 5'd0 && rsD == writeregM_q && RegWriteM_q;
   assign forwardBD = rtD != 5'd0 && rtD == writeregM_q && RegWriteM_q;

   assign lwstall  = MemtoRegE && (rtE == rsD || rtE == rtD);
   assign brstall  = branchD && ((RegWriteE && (writeregE == rsD || writeregE == rtD)) ||
                                 (MemtoRegM_q && (writeregM_q == rsD || writeregM_q == rtD)));
   assign memstall = memaccM_q && !mem_ready && !tmo;

   assign stallB = memstall;
   assign stallF = lwstall | brstall | memstall;
   assign stallD = stallF;
   // a memory hold freezes E too, so the bubble must not overwrite it
   assign flushE = (lwstall | brstall) & !memstall;
   assign flushD = pcsrcD & !stallD;

`ifdef HAZARD_DMEM_TIMEOUT_EN
   localparam logic [0:0] RUN  = 1'b0;
   localparam logic [0:0] WAIT = 1'b1;

   logic [0:0] state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic       mem_err_q;

   assign tmo = state_q == WAIT && cnt_q == 8'(TIMEOUT - 1) && !mem_ready;

   always_comb begin
      state_d = (state_q == RUN) ? (memstall ? WAIT : RUN) : ((mem_ready || tmo) ? RUN : WAIT);
      cnt_d   = (state_q == RUN) ? 8'd0 : cnt_q + 8'd1;
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q   <= RUN;
         cnt_q     <= 8'd0;
         mem_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         mem_err_q <= mem_err_q | tmo;
      end

   assign mem_err = mem_err_q;
`else
   assign tmo     = 1'b0;
   assign mem_err = 1'b0;
`endif
endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: directed and random stimulus checked against a stage-queue model of the hazard rules.
module tb_hazard_unit;
   localparam int TMO = 4;
`ifdef HAZARD_DMEM_TIMEOUT_EN
   localparam bit TEN = 1'b1;
`else
   localparam bit TEN = 1'b0;
`endif

   logic       clk = 1'b0, rst_n = 1'b0;
   logic [4:0] rsD, rtD, rsE, rtE, writeregE;
   logic       branchD, pcsrcD, RegWriteE, MemtoRegE, MemWriteE, mem_ready;
   logic       stallF, stallD, flushD, flushE, stallB, forwardAD, forwardBD, mem_err;
   logic [1:0] forwardAE, forwardBE;

   hazard_unit #(.TIMEOUT(TMO)) dut (
      .clk(clk), .rst_n(rst_n), .rsD(rsD), .rtD(rtD), .branchD(branchD), .pcsrcD(pcsrcD),
      .rsE(rsE), .rtE(rtE), .writeregE(writeregE), .RegWriteE(RegWriteE),
      .MemtoRegE(MemtoRegE), .MemWriteE(MemWriteE), .mem_ready(mem_ready),
      .stallF(stallF), .stallD(stallD), .flushD(flushD), .flushE(flushE), .stallB(stallB),
      .forwardAE(forwardAE), .forwardBE(forwardBE), .forwardAD(forwardAD),
      .forwardBD(forwardBD), .mem_err(mem_err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [4:0] dst;
      logic       we;
      logic       mtr;
      logic       macc;
   } stg_t;

   stg_t m_m, m_w;
   int   run;
   bit   err, last_ms, last_to;
   int   n_assert = 0, n_fail = 0;

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_assert++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [1:0] fwd(input logic [4:0] r);
      if (r == 5'd0) return 2'b00;
      if (r == m_m.dst && m_m.we) return 2'b10;
      if (r == m_w.dst && m_w.we) return 2'b01;
      return 2'b00;
   endfunction

   task automatic model_reset();
      m_m = '0;
      m_w = '0;
      run = 0;
      err = 1'b0;
   endtask

   task automatic sample();
      logic lw, br, to, ms, hold;
      #1;
      lw   = MemtoRegE && (rtE == rsD || rtE == rtD);
      br   = branchD && ((RegWriteE && (writeregE == rsD || writeregE == rtD)) ||
                         (m_m.mtr && (m_m.dst == rsD || m_m.dst == rtD)));
      to   = TEN && m_m.macc && !mem_ready && run == TMO;
      ms   = m_m.macc && !mem_ready && !to;
      hold = lw | br | ms;
      chk("stallF", 8'(stallF), 8'(hold));
      chk("stallD", 8'(stallD), 8'(hold));
      chk("flushD", 8'(flushD), 8'(pcsrcD && !hold));
      chk("flushE", 8'(flushE), 8'((lw | br) && !ms));
      chk("stallB", 8'(stallB), 8'(ms));
      chk("forwardAE", 8'(forwardAE), 8'(fwd(rsE)));
      chk("forwardBE", 8'(forwardBE), 8'(fwd(rtE)));
      chk("forwardAD", 8'(forwardAD), 8'(fwd(rsD) == 2'b10));
      chk("forwardBD", 8'(forwardBD), 8'(fwd(rtD) == 2'b10));
      chk("mem_err", 8'(mem_err), 8'(err));
      last_ms = ms;
      last_to = to;
   endtask

   task automatic finish_cycle();
      if (!last_ms) begin
         m_w = m_m;
         m_m = '{writeregE, RegWriteE, MemtoRegE, MemtoRegE | MemWriteE};
      end
      run = last_ms ? run + 1 : 0;
      err = err | last_to;
      @(negedge clk);
   endtask

   task automatic step();
      sample();
      finish_cycle();
   endtask

   task automatic set_in(input logic [4:0] rsd, rtd, input logic br, pcs,
                         input logic [4:0] rse, rte, wre, input logic rw, mtr, mw, rdy);
      rsD = rsd; rtD = rtd; branchD = br; pcsrcD = pcs;
      rsE = rse; rtE = rte; writeregE = wre;
      RegWriteE = rw; MemtoRegE = mtr; MemWriteE = mw; mem_ready = rdy;
   endtask

   task automatic idle();
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
   endtask

   int scnt;

   initial begin
      idle();
      model_reset();
      @(negedge clk);
      sample();
      rst_n = 1'b1;
      finish_cycle();

      // forwarding priority
      set_in(0, 0, 0, 0, 0, 0, 5, 1, 0, 0, 1); step();
      step();
      set_in(0, 0, 0, 0, 5, 0, 5, 0, 0, 0, 1);
      sample(); chk("fwd_M_prio", 8'(forwardAE), 8'h2); finish_cycle();
      set_in(0, 0, 0, 0, 5, 0, 0, 0, 0, 0, 1);
      sample(); chk("fwd_W", 8'(forwardAE), 8'h1); finish_cycle();
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      sample(); chk("fwd_zero", 8'(forwardAE), 8'h0); finish_cycle();

      // load-use
      set_in(8, 0, 0, 0, 0, 8, 8, 1, 1, 0, 1);
      sample(); chk("lu_stall", 8'({stallF, stallD, flushE}), 8'h7); finish_cycle();
      set_in(8, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      sample(); chk("lu_release", 8'({stallF, stallD, flushE}), 8'h0); finish_cycle();
      idle(); step(); step();

      // branch depending on a load in E
      set_in(9, 0, 1, 1, 0, 9, 9, 1, 1, 0, 1);
      sample(); chk("br_ld1", 8'({stallD, flushD}), 8'h2); finish_cycle();
      set_in(9, 0, 1, 1, 0, 0, 0, 0, 0, 0, 1);
      sample(); chk("br_ld2", 8'({stallD, flushD}), 8'h2); finish_cycle();
      sample(); chk("br_ld3", 8'({stallD, flushD, forwardAD}), 8'h2); finish_cycle();
      idle(); step(); step();

      // memory wait with a concurrent load-use
      set_in(0, 0, 0, 0, 0, 7, 7, 1, 1, 0, 1); step();
      for (int i = 0; i < 3; i++) begin
         set_in(4, 0, 0, 0, 0, 4, 4, 1, 1, 0, 0);
         sample(); chk("mw_hold", 8'({stallB, stallF, flushE}), 8'h6); finish_cycle();
      end
      set_in(4, 0, 0, 0, 0, 4, 4, 1, 1, 0, 1);
      sample(); chk("mw_release", 8'(stallB), 8'h0); finish_cycle();
      set_in(0, 0, 0, 0, 7, 0, 0, 0, 0, 0, 1);
      sample(); chk("mw_W_upd", 8'(forwardAE), 8'h1); finish_cycle();
      idle(); step(); step();

`ifdef HAZARD_DMEM_TIMEOUT_EN
      set_in(0, 0, 0, 0, 0, 6, 6, 1, 1, 0, 1); step();
      scnt = 0;
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 8; i++) begin
         sample();
         if (stallB) scnt++;
         finish_cycle();
      end
      chk("tmo_len", 8'(scnt), 8'(TMO));
      sample(); chk("tmo_err", 8'(mem_err), 8'h1); finish_cycle();
      #2 rst_n = 1'b0;
      model_reset();
      sample(); chk("tmo_err_rst", 8'(mem_err), 8'h0);
      @(negedge clk);
      rst_n = 1'b1;
      idle(); step();
`endif

      // reset in the middle of a memory wait
      set_in(0, 0, 0, 0, 0, 10, 10, 1, 1, 0, 1); step();
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); step();
      sample(); chk("wait_pre", 8'(stallB), 8'h1); finish_cycle();
      #2 rst_n = 1'b0;
      model_reset();
      sample(); chk("rst_mid", 8'({stallF, stallD, stallB, flushE, flushD}), 8'h0);
      @(negedge clk);
      rst_n = 1'b1;
      set_in(0, 0, 0, 0, 10, 10, 0, 0, 0, 0, 1);
      sample(); chk("rst_fwd", 8'({forwardAE, forwardBE}), 8'h0); finish_cycle();

      for (int i = 0; i < 3000; i++) begin
         set_in(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), ($urandom % 3) == 0,
                ($urandom % 2) == 0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                5'($urandom_range(0, 3)), ($urandom % 2) == 0, ($urandom % 4) == 0,
                ($urandom % 5) == 0, ($urandom % 4) != 0);
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline hazard controller for the five-stage core. It consumes the decode-stage source registers and the execute-stage outputs of the ID/EX register, and drives that register's `clr` (flushE). It also drives the fetch/decode stall and flush lines, the forwarding selects, and a back-end stall for multi-cycle data-memory accesses. The unit keeps its own shadow copy of the M/W destination and control bits, so forwarding and stall decisions need no extra taps on the downstream pipeline registers.

## Interface
Parameters:
- `TIMEOUT`, default 16: maximum cycles a data-memory access may stall before forced release; legal range 2..255.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `rsD`, `rtD`  in  5 each  decode-stage source register numbers.
- `branchD`  in  1  branch instruction in decode.
- `pcsrcD`  in  1  branch taken, resolved in decode.
- `rsE`, `rtE`  in  5 each  execute-stage source registers.
- `writeregE`  in  5  execute-stage destination, after the RegDst mux.
- `RegWriteE`, `MemtoRegE`, `MemWriteE`  in  1 each  execute-stage control bits.
- `mem_ready`  in  1  data memory completes the current M-stage access this cycle.
- `stallF`, `stallD`  out  1 each  hold PC and the IF/ID register.
- `flushD`  out  1  clear IF/ID.
- `flushE`  out  1  drives ID/EX `clr`.
- `stallB`  out  1  hold the E/M/W pipeline registers (back-end stall).
- `forwardAE`, `forwardBE`  out  2 each  ALU operand select: 00 register file, 10 from M, 01 from W.
- `forwardAD`, `forwardBD`  out  1 each  branch comparator operand forwarded from M.
- `mem_err`  out  1  sticky flag: an access timed out.

## Operation
- Shadow pipeline: registers `writeregM/W`, `RegWriteM/W`, `MemtoRegM`, `memaccM` (= `MemtoRegE|MemWriteE`). When `stallB`=0, E→M and M→W on each edge; when `stallB`=1, all shadow registers hold.
- Forwarding, combinational from shadow state:
  - `forwardAE`=10 if `rsE`≠0 && `rsE`==`writeregM` && `RegWriteM`; else 01 if `rsE`≠0 && `rsE`==`writeregW` && `RegWriteW`; else 00. M takes priority over W.
  - `forwardBE` is the same rule using `rtE`.
  - `forwardAD` = `rsD`≠0 && `rsD`==`writeregM` && `RegWriteM`; `forwardBD` is the same rule using `rtD`.
- `lwstall` = `MemtoRegE` && (`rtE`==`rsD` || `rtE`==`rtD`).
- `brstall` = `branchD` && ((`RegWriteE` && `writeregE`∈{`rsD`,`rtD`}) || (`MemtoRegM` && `writeregM`∈{`rsD`,`rtD`})).
- `memstall` = `memaccM` && !`mem_ready` && !`tmo`.
- Stall and flush outputs:
  - `stallB` = `memstall`.
  - `stallF` = `stallD` = `lwstall` | `brstall` | `memstall`.
  - `flushE` = (`lwstall` | `brstall`) & !`memstall`.
  - `flushD` = `pcsrcD` & !`stallD`.
- FSM, two states:
  - RUN → WAIT on an edge where `memstall`=1; the wait counter `cnt` is cleared to 0 on entry.
  - In WAIT, `cnt` increments each cycle. WAIT → RUN on an edge where `mem_ready`=1, or where `tmo` fires.
- `tmo`: defined only under the configuration macro; see Configuration.

## Timing
- Forward, stall and flush outputs are combinational from inputs plus registered state; zero-cycle latency.
- Load-use stall lasts exactly 1 cycle: E holds a bubble on the next cycle, so `MemtoRegE`=0.
- Branch stall: 1 cycle for a dependency in E (ALU op) or in M (load); 2 cycles for a load in E.
- Memory wait: `stallB` is high for every cycle in which `mem_ready`=0, and low in the cycle `mem_ready`=1.
- Simultaneous `memstall` and `lwstall`: the whole pipe holds and `flushE`=0, so no instruction is lost.
- Reset (asynchronous, including mid-WAIT):
  - state RUN, `cnt`=0, all shadow registers 0, `mem_err`=0.
  - With E/D inputs at 0, every output reads 0.

## Configuration
- `HAZARD_DMEM_TIMEOUT_EN` defined:
  - `tmo` = (state==WAIT && `cnt`==`TIMEOUT`-1 && !`mem_ready`).
  - When `tmo` fires: `stallB` drops that cycle, the shadow pipeline advances, `mem_err` sets and stays high until reset.
- Undefined: `tmo`=0, `mem_err` is tied 0, no counter exists, and the core stalls indefinitely on a memory wait.

## Test plan
- Forward priority: M has `writeregM`=5 with `RegWriteM`=1, W also writes 5, `rsE`=5 → `forwardAE`=10; drop `RegWriteM` → 01; `rsE`=0 with `writeregM`=0 → 00.
- Load-use: `MemtoRegE`=1, `rtE`=8, `rsD`=8 → `stallF`=`stallD`=`flushE`=1 for one cycle, then all 0.
- Branch on a load in E: `branchD`=1, `rsD`=9, `MemtoRegE`=1, `writeregE`=9 → stall for 2 cycles, then `forwardAD`=0 (value now in W, read from the register file).
- Memory wait: load in M, `mem_ready` low for 3 cycles → `stallB`=`stallF`=1 for exactly 3 cycles, `flushE`=0 throughout, shadow W updated on the 4th edge.
- Timeout (macro on, `TIMEOUT`=4): `mem_ready` held 0 → `stallB` high 4 cycles then low; `mem_err`=1 sticky; reset clears it.
- Reset asserted mid-WAIT → state RUN, all outputs 0 immediately; after release, forwarding stays 00 until new writes propagate.
